// File: rtl/ssd_accum_min.sv
// ssd_accum_min: accumulates per-candidate sums of squared differences and tracks the minimum SSD per search.
module ssd_accum_min #(
  parameter int N_SAMP = 64,
  parameter int N_CAND = 16,
  parameter int ACC_W  = 22,
  parameter int IDX_W  = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             din_vld,
  input  logic [15:0]      din,
  output logic             busy,
  output logic             ssd_vld,
  output logic [ACC_W-1:0] ssd,
  output logic [IDX_W-1:0] ssd_idx,
  output logic [ACC_W-1:0] min_ssd,
  output logic [IDX_W-1:0] min_idx,
  output logic             search_done
);
  localparam int SC_W = $clog2(N_SAMP);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, ssd_q, ssd_d, min_q, min_d, total;
  logic [SC_W-1:0]  samp_q, samp_d;
  logic [IDX_W-1:0] cand_q, cand_d, ssd_idx_q, ssd_idx_d, min_idx_q, min_idx_d;
  logic             first_q, first_d, busy_q, busy_d, vld_q, vld_d, done_q, done_d, last;
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    samp_d    = samp_q;
    cand_d    = cand_q;
    first_d   = first_q;
    busy_d    = busy_q;
    ssd_d     = ssd_q;
    ssd_idx_d = ssd_idx_q;
    min_d     = min_q;
    min_idx_d = min_idx_q;
    vld_d     = 1'b0;
    done_d    = 1'b0;
    total     = acc_q + ACC_W'(din);
    last      = samp_q == SC_W'(N_SAMP - 1);
    if (start) begin
      state_d = ACCUM;
      acc_d   = '0;
      samp_d  = '0;
      cand_d  = '0;
      first_d = 1'b1;
      busy_d  = 1'b1;
    end else if (state_q == ACCUM && din_vld) begin
      if (last) begin
        ssd_d     = total;
        ssd_idx_d = cand_q;
        vld_d     = 1'b1;
        first_d   = 1'b0;
        acc_d     = '0;
        samp_d    = '0;
        // strict compare: a tie keeps the earlier candidate
        if (first_q || total < min_q) begin
          min_d     = total;
          min_idx_d = cand_q;
        end
        if (cand_q == IDX_W'(N_CAND - 1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cand_d = cand_q + 1'b1;
        end
      end else begin
        acc_d  = total;
        samp_d = samp_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      samp_q    <= '0;
      cand_q    <= '0;
      first_q   <= 1'b0;
      busy_q    <= 1'b0;
      ssd_q     <= '0;
      ssd_idx_q <= '0;
      min_q     <= '0;
      min_idx_q <= '0;
      vld_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      samp_q    <= samp_d;
      cand_q    <= cand_d;
      first_q   <= first_d;
      busy_q    <= busy_d;
      ssd_q     <= ssd_d;
      ssd_idx_q <= ssd_idx_d;
      min_q     <= min_d;
      min_idx_q <= min_idx_d;
      vld_q     <= vld_d;
      done_q    <= done_d;
    end
  end
  assign busy        = busy_q;
  assign ssd_vld     = vld_q;
  assign ssd         = ssd_q;
  assign ssd_idx     = ssd_idx_q;
  assign min_ssd     = min_q;
  assign min_idx     = min_idx_q;
  assign search_done = done_q;
endmodule

// File: tb/tb_ssd_accum_min.sv
// tb_ssd_accum_min: directed checks of ssd_accum_min with one-candidate and four-candidate instances on shared inputs.
module tb_ssd_accum_min;
  logic        clk = 1'b0, nrst = 1'b0, start = 1'b0, din_vld = 1'b0;
  logic [15:0] din = '0;
  logic        u1_busy, u1_vld, u1_done, u4_busy, u4_vld, u4_done;
  logic [21:0] u1_ssd, u1_min, u4_ssd, u4_min;
  logic [7:0]  u1_idx, u1_midx, u4_idx, u4_midx;
  int          checks = 0, errors = 0, vld1_n = 0, vld4_n = 0, done4_n = 0;
  always #5 clk = ~clk;
  ssd_accum_min #(.N_SAMP(64), .N_CAND(1), .ACC_W(22), .IDX_W(8)) u_dut1 (
    .clk(clk), .nrst(nrst), .start(start), .din_vld(din_vld), .din(din),
    .busy(u1_busy), .ssd_vld(u1_vld), .ssd(u1_ssd), .ssd_idx(u1_idx),
    .min_ssd(u1_min), .min_idx(u1_midx), .search_done(u1_done));
  ssd_accum_min #(.N_SAMP(64), .N_CAND(4), .ACC_W(22), .IDX_W(8)) u_dut4 (
    .clk(clk), .nrst(nrst), .start(start), .din_vld(din_vld), .din(din),
    .busy(u4_busy), .ssd_vld(u4_vld), .ssd(u4_ssd), .ssd_idx(u4_idx),
    .min_ssd(u4_min), .min_idx(u4_midx), .search_done(u4_done));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // drive one cycle at the falling edge; outputs are observed at the following falling edge
  task automatic cyc(input logic v, input logic [15:0] d, input logic s);
    din_vld = v;
    din     = d;
    start   = s;
    @(negedge clk);
    vld1_n  += int'(u1_vld);
    vld4_n  += int'(u4_vld);
    done4_n += int'(u4_done);
  endtask
  initial begin
    int vals [4];
    int exp_min, exp_midx;
    vals = '{9, 4, 4, 16};
    @(negedge clk);
    chk("rst_vld", u1_vld, 0);
    chk("rst_busy", u1_busy, 0);
    chk("rst_ssd", u4_ssd, 0);
    chk("rst_min", u4_min, 0);
    nrst = 1'b1;
    cyc(0, 0, 0);
    // 1: single candidate of ones
    cyc(0, 0, 1);
    chk("t1_busy", u1_busy, 1);
    vld1_n = 0;
    for (int i = 0; i < 63; i++) cyc(1, 1, 0);
    chk("t1_early", vld1_n, 0);
    cyc(1, 1, 0);
    chk("t1_vld", u1_vld, 1);
    chk("t1_ssd", u1_ssd, 64);
    chk("t1_idx", u1_idx, 0);
    chk("t1_min", u1_min, 64);
    chk("t1_midx", u1_midx, 0);
    chk("t1_done", u1_done, 1);
    chk("t1_busy_lo", u1_busy, 0);
    cyc(0, 0, 0);
    chk("t1_vld_lo", u1_vld, 0);
    chk("t1_hold", u1_ssd, 64);
    // 2: four back-to-back candidates, tie keeps the earlier index
    cyc(0, 0, 1);
    vld4_n = 0;
    done4_n = 0;
    exp_min = 0;
    exp_midx = 0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 64; i++) cyc(1, 16'(vals[k]), 0);
      if (k == 0 || vals[k] * 64 < exp_min) begin
        exp_min = vals[k] * 64;
        exp_midx = k;
      end
      chk("t2_vld", u4_vld, 1);
      chk("t2_ssd", u4_ssd, 32'(vals[k] * 64));
      chk("t2_idx", u4_idx, 32'(k));
      chk("t2_min", u4_min, 32'(exp_min));
      chk("t2_midx", u4_midx, 32'(exp_midx));
      chk("t2_done", u4_done, k == 3 ? 1 : 0);
    end
    cyc(0, 0, 0);
    chk("t2_pulses", vld4_n, 4);
    chk("t2_done_n", done4_n, 1);
    chk("t2_busy_lo", u4_busy, 0);
    chk("t2_min_hold", u4_min, 256);
    // 3: maximum input, no wrap
    cyc(0, 0, 1);
    for (int i = 0; i < 64; i++) cyc(1, 16'hFE01, 0);
    chk("t3_ssd", u1_ssd, 4161600);
    chk("t3_done", u1_done, 1);
    // 4: ramp with gaps
    cyc(0, 0, 1);
    vld1_n = 0;
    for (int i = 0; i < 63; i++) begin
      if (i % 3 == 0) cyc(0, 16'hFFFF, 0);
      cyc(1, 16'(i), 0);
    end
    for (int i = 0; i < 5; i++) cyc(0, 16'hFFFF, 0);
    chk("t4_early", vld1_n, 0);
    cyc(1, 63, 0);
    chk("t4_vld", u1_vld, 1);
    chk("t4_ssd", u1_ssd, 2016);
    cyc(0, 0, 0);
    chk("t4_pulses", vld1_n, 1);
    // 5: abort mid-candidate; start-cycle data discarded
    cyc(0, 0, 1);
    vld1_n = 0;
    for (int i = 0; i < 30; i++) cyc(1, 7, 0);
    cyc(1, 1000, 1);
    chk("t5_min_kept", u1_min, 2016);
    for (int i = 0; i < 64; i++) cyc(1, 2, 0);
    chk("t5_ssd", u1_ssd, 128);
    chk("t5_idx", u1_idx, 0);
    chk("t5_min", u1_min, 128);
    cyc(0, 0, 0);
    chk("t5_pulses", vld1_n, 1);
    // 6: async reset mid-accumulation, then data without start
    cyc(0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(1, 5, 0);
    #1 nrst = 1'b0;
    #1;
    chk("t6_busy", u4_busy, 0);
    chk("t6_ssd", u4_ssd, 0);
    chk("t6_min", u4_min, 0);
    chk("t6_midx", u1_midx, 0);
    @(negedge clk);
    nrst = 1'b1;
    vld1_n = 0;
    vld4_n = 0;
    for (int i = 0; i < 70; i++) cyc(1, 3, 0);
    cyc(0, 0, 0);
    chk("t6_no_vld1", vld1_n, 0);
    chk("t6_no_vld4", vld4_n, 0);
    chk("t6_busy_lo", u1_busy, 0);
    chk("t6_ssd_lo", u1_ssd, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
